i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx_if.sv | 33 +++
 rtl/i2s_tx.sv | 140 ++++++++++++++
 tb/tb_i2s_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// I2S transmitter bundle: parallel stereo input handshake
// plus the registered serial outputs.
interface i2s_tx_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_ready;
  logic              out_valid;
  logic              WS;
  logic              SD;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready,
    input  out_valid,
    input  WS,
    input  SD
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready,
    output out_valid,
    output WS,
    output SD
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry holding buffer feeding a
// left/right serializer, MSB first, gapless frames.
module i2s_tx #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  i2s_tx_if.slave  bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shl_q, shl_d;
  logic [DATA_W-1:0] shr_q, shr_d;
  logic [DATA_W-1:0] hl_q, hl_d;
  logic [DATA_W-1:0] hr_q, hr_d;
  logic              full_q, full_d;
  logic              ov_q, ov_d;
  logic              ws_q, ws_d;
  logic              sd_q, sd_d;
  logic              accept;

  // in_ready comes straight from the buffer flag register
  assign accept        = bus.in_valid & ~full_q;
  assign bus.in_ready  = ~full_q;
  assign bus.out_valid = ov_q;
  assign bus.WS        = ws_q;
  assign bus.SD        = sd_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shl_q   <= '0;
      shr_q   <= '0;
      hl_q    <= '0;
      hr_q    <= '0;
      full_q  <= 1'b0;
      ov_q    <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      hl_q    <= hl_d;
      hr_q    <= hr_d;
      full_q  <= full_d;
      ov_q    <= ov_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
    end
  end

  // Next-state: buffer capture, frame load and bit shifting.
  // The output regs hold the bit shown during the next cycle,
  // so a load emits the left MSB directly from the buffer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    shr_d   = shr_q;
    hl_d    = hl_q;
    hr_d    = hr_q;
    full_d  = full_q;
    ov_d    = 1'b0;
    ws_d    = 1'b0;
    sd_d    = 1'b0;

    if (accept) begin
      hl_d   = bus.in_left;
      hr_d   = bus.in_right;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (full_q) begin
          state_d = LEFT;
          shl_d   = hl_q << 1;
          shr_d   = hr_q;
          cnt_d   = '0;
          full_d  = 1'b0;
          ov_d    = 1'b1;
          sd_d    = hl_q[DATA_W-1];
        end
      end
      LEFT: begin
        ov_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RIGHT;
          cnt_d   = '0;
          ws_d    = 1'b1;
          sd_d    = shr_q[DATA_W-1];
          shr_d   = shr_q << 1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          sd_d  = shl_q[DATA_W-1];
          shl_d = shl_q << 1;
        end
      end
      RIGHT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (full_q) begin
            state_d = LEFT;
            shl_d   = hl_q << 1;
            shr_d   = hr_q;
            full_d  = 1'b0;
            ov_d    = 1'b1;
            sd_d    = hl_q[DATA_W-1];
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          ov_d  = 1'b1;
          ws_d  = 1'b1;
          sd_d  = shr_q[DATA_W-1];
          shr_d = shr_q << 1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: 32-bit and 8-bit instances,
// frame capture, back-to-back, blocking, zero and reset.
module tb_i2s_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  i2s_tx_if #(.DATA_W(32)) b32 ();
  i2s_tx_if #(.DATA_W(8))  b8 ();

  i2s_tx #(.DATA_W(32)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
  );

  i2s_tx #(.DATA_W(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send32(input logic [31:0] l,
                        input logic [31:0] r);
    b32.in_left  = l;
    b32.in_right = r;
    b32.in_valid = 1'b1;
    @(negedge clk);
    b32.in_valid = 1'b0;
  endtask

  task automatic recv32(input  int n,
                        input  bit blk,
                        output logic [127:0] bits,
                        output int ovc,
                        output int wsbad,
                        output int rdylow);
    logic wexp;
    bits   = '0;
    ovc    = 0;
    wsbad  = 0;
    rdylow = 0;
    for (int i = 0; i < n; i++) begin
      wexp = ((i / 32) % 2) == 1;
      bits = {bits[126:0], b32.SD};
      if (b32.out_valid === 1'b1) ovc++;
      if (b32.WS !== wexp) wsbad++;
      if (b32.in_ready !== 1'b1) rdylow++;
      if (i == 1) b32.in_valid = 1'b0;
      if (blk && i == 5) begin
        b32.in_left  = 32'hDEAD_BEEF;
        b32.in_right = 32'hDEAD_BEEF;
        b32.in_valid = 1'b1;
      end
      if (blk && i == 10) b32.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [127:0] bits;
    logic [15:0]  bits8;
    int ovc, wsbad, rdylow, n;

    rst_n = 1'b0;
    b32.in_valid = 1'b0;
    b32.in_left  = '0;
    b32.in_right = '0;
    b8.in_valid  = 1'b0;
    b8.in_left   = '0;
    b8.in_right  = '0;
    repeat (2) @(negedge clk);

    chk("rst_ov", b32.out_valid, 0);
    chk("rst_ws", b32.WS, 0);
    chk("rst_sd", b32.SD, 0);
    chk("rst_rdy", b32.in_ready, 1);
    chk("rst8_ov", b8.out_valid, 0);
    chk("rst8_rdy", b8.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single frame
    send32(32'h8000_0001, 32'hFFFF_0000);
    chk("t1_rdy_lo", b32.in_ready, 0);
    chk("t1_ov_lat", b32.out_valid, 0);
    @(negedge clk);
    chk("t1_rdy_hi", b32.in_ready, 1);
    recv32(64, 1'b0, bits, ovc, wsbad, rdylow);
    chk("t1_bits", bits, {64'h0, 32'h8000_0001, 32'hFFFF_0000});
    chk("t1_ovc", ovc, 64);
    chk("t1_ws", wsbad, 0);
    chk("t1_end_ov", b32.out_valid, 0);
    chk("t1_end_ws", b32.WS, 0);
    chk("t1_end_sd", b32.SD, 0);

    // back-to-back
    send32(32'hA1B2_C3D4, 32'h0123_4567);
    @(negedge clk);
    b32.in_left  = 32'h89AB_CDEF;
    b32.in_right = 32'h7654_3210;
    b32.in_valid = 1'b1;
    recv32(128, 1'b0, bits, ovc, wsbad, rdylow);
    chk("t2_bits", bits, {32'hA1B2_C3D4, 32'h0123_4567,
                          32'h89AB_CDEF, 32'h7654_3210});
    chk("t2_ovc", ovc, 128);
    chk("t2_ws", wsbad, 0);
    chk("t2_rdylow", rdylow, 63);
    chk("t2_end_ov", b32.out_valid, 0);

    // blocked input while buffer full
    send32(32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    b32.in_left  = 32'h0F0F_0F0F;
    b32.in_right = 32'hF0F0_F0F0;
    b32.in_valid = 1'b1;
    recv32(128, 1'b1, bits, ovc, wsbad, rdylow);
    chk("t3_bits", bits, {32'h1234_5678, 32'h9ABC_DEF0,
                          32'h0F0F_0F0F, 32'hF0F0_F0F0});
    chk("t3_ovc", ovc, 128);
    chk("t3_ws", wsbad, 0);
    chk("t3_rdy", b32.in_ready, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (b32.out_valid === 1'b1) n++;
      @(negedge clk);
    end
    chk("t3_no_extra", n, 0);

    // zero frame
    send32(32'h0, 32'h0);
    @(negedge clk);
    recv32(64, 1'b0, bits, ovc, wsbad, rdylow);
    chk("t4_bits", bits, 128'h0);
    chk("t4_ovc", ovc, 64);
    chk("t4_ws", wsbad, 0);
    chk("t4_end_ov", b32.out_valid, 0);

    // reset during the 10th left bit
    send32(32'h1122_3344, 32'h5566_7788);
    @(negedge clk);
    repeat (9) @(negedge clk);
    chk("t5_pre_ov", b32.out_valid, 1);
    rst_n = 1'b0;
    b32.in_left  = 32'hFFFF_FFFF;
    b32.in_right = 32'hFFFF_FFFF;
    b32.in_valid = 1'b1;
    #1;
    chk("t5_ov", b32.out_valid, 0);
    chk("t5_ws", b32.WS, 0);
    chk("t5_sd", b32.SD, 0);
    chk("t5_rdy", b32.in_ready, 1);
    repeat (2) @(negedge clk);
    chk("t5_rdy_hold", b32.in_ready, 1);
    b32.in_valid = 1'b0;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (b32.out_valid !== 1'b0) n++;
      @(negedge clk);
    end
    chk("t5_silent", n, 0);
    chk("t5_rdy_end", b32.in_ready, 1);

    // 8-bit instance
    b8.in_left  = 8'hA5;
    b8.in_right = 8'h3C;
    b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    chk("t6_rdy_lo", b8.in_ready, 0);
    @(negedge clk);
    bits8 = '0;
    ovc = 0;
    wsbad = 0;
    for (int i = 0; i < 16; i++) begin
      bits8 = {bits8[14:0], b8.SD};
      if (b8.out_valid === 1'b1) ovc++;
      if (b8.WS !== (i >= 8)) wsbad++;
      @(negedge clk);
    end
    chk("t6_bits", bits8, 16'hA53C);
    chk("t6_ovc", ovc, 16);
    chk("t6_ws", wsbad, 0);
    chk("t6_end_ov", b8.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
